// File: rtl/chicken_pkg.sv
// Shared types and default sizing for the Chicken Cha-Cha-Cha turn scheduler.
// Optional feature macro used by the scheduler: TURN_TIMEOUT_EN.
package chicken_pkg;

    typedef enum logic [2:0] {
        IDLE,
        WAIT_KEY,
        REVEAL,
        SHOW,
        RESOLVE,
        WIN
    } state_t;

    // Index width for a range of n values; never narrower than one bit.
    function automatic int idxWidth(input int n);
        return (n > 2) ? $clog2(n) : 1;
    endfunction

    localparam int DEF_NUM_PLAYERS    = 4;
    localparam int DEF_TRACK_LEN      = 24;
    localparam int DEF_NUM_CARDS      = 12;
    localparam int DEF_REVEAL_CYCLES  = 50_000_000;
    localparam int DEF_TIMEOUT_CYCLES = 500_000_000;

    localparam int PLAYER_W = idxWidth(DEF_NUM_PLAYERS);
    localparam int POS_W    = idxWidth(DEF_TRACK_LEN);
    localparam int CARD_W   = idxWidth(DEF_NUM_CARDS);

endpackage

// File: rtl/chicken_turn_scheduler_hold_timer.sv
// Loadable down-counter; o_done strobes in the last enabled cycle of a loaded interval.
module hold_timer
#(
    parameter int WIDTH = 32
)
(
    input  logic             i_clk,
    input  logic             i_rst_n,
    input  logic             i_load,
    input  logic [WIDTH-1:0] i_loadValue,
    input  logic             i_en,
    output logic             o_done
);

    logic [WIDTH-1:0] r_count;

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_count <= '0;
        end else if (i_load) begin
            r_count <= i_loadValue;
        end else if (i_en && (r_count != '0)) begin
            r_count <= r_count - 1'b1;
        end
    end

    assign o_done = i_en && (r_count == WIDTH'(1));

endmodule

// File: rtl/chicken_turn_scheduler.sv
// Turn scheduler: owns the card reveal handshake, chicken positions and win detection.
// Define TURN_TIMEOUT_EN to forfeit a turn after TIMEOUT_CYCLES without a key.
module chicken_turn_scheduler
    import chicken_pkg::*;
#(
    parameter int NUM_PLAYERS    = DEF_NUM_PLAYERS,
    parameter int TRACK_LEN      = DEF_TRACK_LEN,
    parameter int NUM_CARDS      = DEF_NUM_CARDS,
    parameter int REVEAL_CYCLES  = DEF_REVEAL_CYCLES,
    parameter int TIMEOUT_CYCLES = DEF_TIMEOUT_CYCLES,
    localparam int PLAYER_BITS   = idxWidth(NUM_PLAYERS),
    localparam int POS_BITS      = idxWidth(TRACK_LEN),
    localparam int CARD_BITS     = idxWidth(NUM_CARDS)
)
(
    input  logic                   i_clk,
    input  logic                   i_rst_n,
    input  logic                   i_start,
    input  logic [NUM_PLAYERS-1:0] i_key,
    input  logic [CARD_BITS-1:0]   i_card_sel,
    output logic                   o_reveal_req,
    output logic [CARD_BITS-1:0]   o_reveal_idx,
    input  logic                   i_reveal_ack,
    input  logic                   i_match,
    output logic [PLAYER_BITS-1:0] o_cur_player,
    output logic [POS_BITS-1:0]    o_cur_pos,
    output logic                   o_showing,
    output logic                   o_advance,
    output logic                   o_hide,
    output logic                   o_win_valid,
    output logic [PLAYER_BITS-1:0] o_winner
);

    localparam int HOLD_MAX   = (REVEAL_CYCLES > TIMEOUT_CYCLES) ? REVEAL_CYCLES : TIMEOUT_CYCLES;
    localparam int TIMER_BITS = idxWidth(HOLD_MAX + 1);
    localparam logic [POS_BITS-1:0]    LAST_TILE   = POS_BITS'(TRACK_LEN - 1);
    localparam logic [PLAYER_BITS-1:0] LAST_PLAYER = PLAYER_BITS'(NUM_PLAYERS - 1);

    state_t                 r_state;
    state_t                 w_nextState;
    logic [POS_BITS-1:0]    r_pos [NUM_PLAYERS];
    logic [PLAYER_BITS-1:0] r_curPlayer;
    logic [POS_BITS-1:0]    r_curPos;
    logic [CARD_BITS-1:0]   r_revealIdx;
    logic                   r_match;
    logic [PLAYER_BITS-1:0] r_winner;

    logic r_revealReq, r_showing, r_advance, r_hide, r_winValid;
    logic w_revealReq, w_showing, w_advance, w_hide, w_winValid;

    logic                   w_keyOk;
    logic                   w_enterShow;
    logic                   w_passTurn;
    logic                   w_forfeit;
    logic [PLAYER_BITS-1:0] w_nextPlayer;
    logic                   w_timerLoad;
    logic                   w_timerEn;
    logic                   w_timerDone;
    logic [TIMER_BITS-1:0]  w_timerLoadValue;

    assign w_keyOk      = (r_state == WAIT_KEY) && i_key[r_curPlayer];
    assign w_enterShow  = (r_state == REVEAL) && i_reveal_ack;
    assign w_nextPlayer = (r_curPlayer == LAST_PLAYER) ? '0 : r_curPlayer + 1'b1;

    // The single timer serves the SHOW hold and, when enabled, the key-wait timeout.
`ifdef TURN_TIMEOUT_EN
    assign w_forfeit        = (r_state == WAIT_KEY) && w_timerDone && !w_keyOk;
    assign w_timerEn        = (r_state == SHOW) || (r_state == WAIT_KEY);
    assign w_timerLoad      = w_enterShow ||
                              ((w_nextState == WAIT_KEY) && ((r_state != WAIT_KEY) || w_forfeit));
    assign w_timerLoadValue = w_enterShow ? TIMER_BITS'(REVEAL_CYCLES) : TIMER_BITS'(TIMEOUT_CYCLES);
`else
    assign w_forfeit        = 1'b0;
    assign w_timerEn        = (r_state == SHOW);
    assign w_timerLoad      = w_enterShow;
    assign w_timerLoadValue = TIMER_BITS'(REVEAL_CYCLES);
`endif

    assign w_passTurn = ((r_state == RESOLVE) && !r_match) || w_forfeit;

    hold_timer #(
        .WIDTH (TIMER_BITS)
    ) u_holdTimer (
        .i_clk       (i_clk),
        .i_rst_n     (i_rst_n),
        .i_load      (w_timerLoad),
        .i_loadValue (w_timerLoadValue),
        .i_en        (w_timerEn),
        .o_done      (w_timerDone)
    );

    always_comb begin
        w_nextState = r_state;
        unique case (r_state)
            IDLE:     if (i_start) w_nextState = WAIT_KEY;
            WAIT_KEY: if (w_keyOk) w_nextState = REVEAL;
            REVEAL:   if (i_reveal_ack) w_nextState = SHOW;
            SHOW:     if (w_timerDone) w_nextState = RESOLVE;
            RESOLVE:  w_nextState = (r_match && (r_curPos == LAST_TILE)) ? WIN : WAIT_KEY;
            WIN:      if (i_start) w_nextState = WAIT_KEY;
            default:  w_nextState = IDLE;
        endcase
    end

    // Output values are decoded one cycle early so every port comes straight from a flop.
    always_comb begin
        w_revealReq = (w_nextState == REVEAL);
        w_showing   = (w_nextState == SHOW);
        w_winValid  = (w_nextState == WIN);
        w_advance   = (r_state == SHOW) && w_timerDone && r_match;
        w_hide      = ((r_state == SHOW) && w_timerDone && !r_match) || w_forfeit;
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state     <= IDLE;
            r_revealReq <= 1'b0;
            r_showing   <= 1'b0;
            r_advance   <= 1'b0;
            r_hide      <= 1'b0;
            r_winValid  <= 1'b0;
        end else begin
            r_state     <= w_nextState;
            r_revealReq <= w_revealReq;
            r_showing   <= w_showing;
            r_advance   <= w_advance;
            r_hide      <= w_hide;
            r_winValid  <= w_winValid;
        end
    end

    // Position moves on entry to RESOLVE so cur_pos already shows the new tile with the advance pulse.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            for (int i = 0; i < NUM_PLAYERS; i++) r_pos[i] <= '0;
            r_curPlayer <= '0;
            r_curPos    <= '0;
            r_revealIdx <= '0;
            r_match     <= 1'b0;
            r_winner    <= '0;
        end else begin
            if (((r_state == IDLE) || (r_state == WIN)) && i_start) begin
                for (int i = 0; i < NUM_PLAYERS; i++) r_pos[i] <= '0;
                r_curPlayer <= '0;
                r_curPos    <= '0;
                r_winner    <= '0;
            end
            if (w_keyOk) begin
                r_revealIdx <= i_card_sel;
            end
            if (w_enterShow) begin
                r_match <= i_match;
            end
            if (w_advance && (r_curPos != LAST_TILE)) begin
                r_curPos           <= r_curPos + 1'b1;
                r_pos[r_curPlayer] <= r_curPos + 1'b1;
            end
            if ((r_state == RESOLVE) && (w_nextState == WIN)) begin
                r_winner <= r_curPlayer;
            end
            if (w_passTurn) begin
                r_curPlayer <= w_nextPlayer;
                r_curPos    <= r_pos[w_nextPlayer];
            end
        end
    end

    assign o_reveal_req = r_revealReq;
    assign o_reveal_idx = r_revealIdx;
    assign o_cur_player = r_curPlayer;
    assign o_cur_pos    = r_curPos;
    assign o_showing    = r_showing;
    assign o_advance    = r_advance;
    assign o_hide       = r_hide;
    assign o_win_valid  = r_winValid;
    assign o_winner     = r_winner;

endmodule

// File: tb/tb_chicken_turn_scheduler.sv
// Directed self-checking bench for chicken_turn_scheduler (4 players, 4 tiles, 3-cycle reveal).
// Adds key-wait timeout steps when TURN_TIMEOUT_EN is defined.
module tb_chicken_turn_scheduler;

    logic       clk;
    logic       rst_n;
    logic       i_start;
    logic [3:0] i_key;
    logic [3:0] i_card_sel;
    logic       o_reveal_req;
    logic [3:0] o_reveal_idx;
    logic       i_reveal_ack;
    logic       i_match;
    logic [1:0] o_cur_player;
    logic [1:0] o_cur_pos;
    logic       o_showing;
    logic       o_advance;
    logic       o_hide;
    logic       o_win_valid;
    logic [1:0] o_winner;

    int checkCount = 0;
    int passCount  = 0;

    chicken_turn_scheduler #(
        .NUM_PLAYERS    (4),
        .TRACK_LEN      (4),
        .NUM_CARDS      (12),
        .REVEAL_CYCLES  (3),
        .TIMEOUT_CYCLES (10)
    ) dut (
        .i_clk        (clk),
        .i_rst_n      (rst_n),
        .i_start      (i_start),
        .i_key        (i_key),
        .i_card_sel   (i_card_sel),
        .o_reveal_req (o_reveal_req),
        .o_reveal_idx (o_reveal_idx),
        .i_reveal_ack (i_reveal_ack),
        .i_match      (i_match),
        .o_cur_player (o_cur_player),
        .o_cur_pos    (o_cur_pos),
        .o_showing    (o_showing),
        .o_advance    (o_advance),
        .o_hide       (o_hide),
        .o_win_valid  (o_win_valid),
        .o_winner     (o_winner)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: observed=timeout required=finish");
        $fatal(1, "[TB] watchdog expired");
    end

    // Drive one cycle of inputs, let the edge sample them, then return 1 time unit after it.
    task automatic applyStimulus(input logic start, input logic [3:0] key, input logic [3:0] card,
                                 input logic ack, input logic matchIn);
        i_start      = start;
        i_key        = key;
        i_card_sel   = card;
        i_reveal_ack = ack;
        i_match      = matchIn;
        @(posedge clk);
        #1;
        i_start      = 1'b0;
        i_key        = 4'd0;
        i_reveal_ack = 1'b0;
        i_match      = 1'b0;
    endtask

    task automatic idleCycles(input int n);
        repeat (n) applyStimulus(1'b0, 4'd0, 4'd0, 1'b0, 1'b0);
    endtask

    // Key, immediate ack, then wait out the hold; returns in the RESOLVE cycle.
    task automatic playTurn(input int player, input logic [3:0] card, input logic matchIn);
        applyStimulus(1'b0, 4'(1 << player), card, 1'b0, 1'b0);
        applyStimulus(1'b0, 4'd0, 4'd0, 1'b1, matchIn);
        idleCycles(3);
    endtask

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        checkCount++;
        assert (observed === expected) passCount++;
        else $error("[TB] FAIL %s: observed=%0d expected=%0d", tag, observed, expected);
    endtask

    initial begin
        rst_n        = 1'b0;
        i_start      = 1'b0;
        i_key        = 4'd0;
        i_card_sel   = 4'd0;
        i_reveal_ack = 1'b0;
        i_match      = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        checkOutput("rst_reveal_req", 32'(o_reveal_req), 0);
        checkOutput("rst_showing",    32'(o_showing), 0);
        checkOutput("rst_advance",    32'(o_advance), 0);
        checkOutput("rst_hide",       32'(o_hide), 0);
        checkOutput("rst_win_valid",  32'(o_win_valid), 0);
        checkOutput("rst_cur_player", 32'(o_cur_player), 0);
        checkOutput("rst_cur_pos",    32'(o_cur_pos), 0);
        checkOutput("rst_reveal_idx", 32'(o_reveal_idx), 0);
        rst_n = 1'b1;

        applyStimulus(1'b0, 4'b0001, 4'd5, 1'b0, 1'b0);
        checkOutput("idle_key_ignored", 32'(o_reveal_req), 0);

        applyStimulus(1'b1, 4'd0, 4'd0, 1'b0, 1'b0);
        checkOutput("start_player", 32'(o_cur_player), 0);
        checkOutput("start_pos",    32'(o_cur_pos), 0);

        applyStimulus(1'b0, 4'd0, 4'd0, 1'b1, 1'b1);
        checkOutput("ack_outside_reveal", 32'(o_showing), 0);

        applyStimulus(1'b0, 4'b0010, 4'd7, 1'b0, 1'b0);
        checkOutput("other_key_ignored", 32'(o_reveal_req), 0);

        applyStimulus(1'b0, 4'b0001, 4'd5, 1'b0, 1'b0);
        checkOutput("key0_req", 32'(o_reveal_req), 1);
        checkOutput("key0_idx", 32'(o_reveal_idx), 5);
        idleCycles(1);
        checkOutput("req_held", 32'(o_reveal_req), 1);

        applyStimulus(1'b0, 4'd0, 4'd0, 1'b1, 1'b1);
        checkOutput("ack_req_drop", 32'(o_reveal_req), 0);
        checkOutput("show_c1",      32'(o_showing), 1);
        for (int i = 2; i <= 3; i++) begin
            idleCycles(1);
            checkOutput($sformatf("show_c%0d", i), 32'(o_showing), 1);
            checkOutput($sformatf("no_adv_c%0d", i), 32'(o_advance), 0);
        end
        idleCycles(1);
        checkOutput("resolve_show_off", 32'(o_showing), 0);
        checkOutput("resolve_advance",  32'(o_advance), 1);
        checkOutput("resolve_no_hide",  32'(o_hide), 0);
        checkOutput("match_pos",        32'(o_cur_pos), 1);
        checkOutput("match_player",     32'(o_cur_player), 0);
        idleCycles(1);
        checkOutput("advance_single", 32'(o_advance), 0);
        checkOutput("same_player",    32'(o_cur_player), 0);

        playTurn(0, 4'd2, 1'b0);
        checkOutput("miss_hide",    32'(o_hide), 1);
        checkOutput("miss_no_adv",  32'(o_advance), 0);
        idleCycles(1);
        checkOutput("miss_next_player", 32'(o_cur_player), 1);
        checkOutput("miss_next_pos",    32'(o_cur_pos), 0);
        checkOutput("hide_single",      32'(o_hide), 0);

        playTurn(1, 4'd3, 1'b0);
        idleCycles(1);
        playTurn(2, 4'd4, 1'b0);
        idleCycles(1);
        checkOutput("player3_turn", 32'(o_cur_player), 3);

        playTurn(3, 4'd10, 1'b0);
        checkOutput("wrap_hide", 32'(o_hide), 1);
        idleCycles(1);
        checkOutput("wrap_player", 32'(o_cur_player), 0);
        checkOutput("wrap_pos_kept", 32'(o_cur_pos), 1);

        playTurn(0, 4'd1, 1'b0);
        idleCycles(1);
        checkOutput("p1_turn", 32'(o_cur_player), 1);

        playTurn(1, 4'd4, 1'b1);
        checkOutput("p1_pos1", 32'(o_cur_pos), 1);
        idleCycles(1);
        playTurn(1, 4'd6, 1'b1);
        checkOutput("p1_pos2", 32'(o_cur_pos), 2);
        idleCycles(1);
        playTurn(1, 4'd8, 1'b1);
        checkOutput("win_advance",   32'(o_advance), 1);
        checkOutput("win_pos",       32'(o_cur_pos), 3);
        checkOutput("win_not_yet",   32'(o_win_valid), 0);
        idleCycles(1);
        checkOutput("win_valid",  32'(o_win_valid), 1);
        checkOutput("winner",     32'(o_winner), 1);

        applyStimulus(1'b0, 4'b0010, 4'd3, 1'b0, 1'b0);
        checkOutput("win_key_ignored", 32'(o_reveal_req), 0);
        checkOutput("win_held",        32'(o_win_valid), 1);
        applyStimulus(1'b0, 4'd0, 4'd0, 1'b1, 1'b1);
        checkOutput("win_ack_ignored", 32'(o_showing), 0);
        checkOutput("win_pos_held",    32'(o_cur_pos), 3);

        applyStimulus(1'b1, 4'd0, 4'd0, 1'b0, 1'b0);
        checkOutput("restart_win_clear", 32'(o_win_valid), 0);
        checkOutput("restart_player",    32'(o_cur_player), 0);
        checkOutput("restart_pos",       32'(o_cur_pos), 0);
        playTurn(0, 4'd2, 1'b0);
        idleCycles(1);
        checkOutput("restart_p1_player", 32'(o_cur_player), 1);
        checkOutput("restart_p1_pos",    32'(o_cur_pos), 0);

        applyStimulus(1'b0, 4'b0010, 4'd9, 1'b0, 1'b0);
        checkOutput("pre_rst_req", 32'(o_reveal_req), 1);
        checkOutput("pre_rst_idx", 32'(o_reveal_idx), 9);
        #2;
        rst_n = 1'b0;
        #1;
        checkOutput("async_req_drop",  32'(o_reveal_req), 0);
        checkOutput("async_player",    32'(o_cur_player), 0);
        repeat (2) begin
            @(posedge clk);
            #1;
            checkOutput("rst_no_advance", 32'(o_advance), 0);
            checkOutput("rst_no_hide",    32'(o_hide), 0);
            checkOutput("rst_no_show",    32'(o_showing), 0);
        end
        rst_n = 1'b1;

        applyStimulus(1'b1, 4'b0001, 4'd4, 1'b0, 1'b0);
        checkOutput("start_key_dropped", 32'(o_reveal_req), 0);
        idleCycles(1);
        checkOutput("start_key_still_wait", 32'(o_reveal_req), 0);
        applyStimulus(1'b0, 4'b0001, 4'd11, 1'b0, 1'b0);
        checkOutput("after_rst_req", 32'(o_reveal_req), 1);
        checkOutput("after_rst_idx", 32'(o_reveal_idx), 11);

`ifdef TURN_TIMEOUT_EN
        rst_n = 1'b0;
        idleCycles(1);
        rst_n = 1'b1;
        applyStimulus(1'b1, 4'd0, 4'd0, 1'b0, 1'b0);
        idleCycles(9);
        checkOutput("to_no_hide_early", 32'(o_hide), 0);
        checkOutput("to_player_early",  32'(o_cur_player), 0);
        idleCycles(1);
        checkOutput("to_forfeit_hide",   32'(o_hide), 1);
        checkOutput("to_forfeit_player", 32'(o_cur_player), 1);
        idleCycles(9);
        applyStimulus(1'b0, 4'b0010, 4'd6, 1'b0, 1'b0);
        checkOutput("to_key_wins_req",    32'(o_reveal_req), 1);
        checkOutput("to_key_wins_hide",   32'(o_hide), 0);
        checkOutput("to_key_wins_player", 32'(o_cur_player), 1);
`endif

        $display("%0d/%0d checks passed", passCount, checkCount);
        $finish;
    end

endmodule
